// File: rtl/microcode_sequencer.sv
// Microcode address generator: captures an opcode on load, steps through its micro-ops and
// gates the asynchronous ROM word onto the control bus until the END bit or an overrun.
module microcode_sequencer #(
  parameter int unsigned OPCODE_WIDTH = 8,
  parameter int unsigned STEP_WIDTH   = 4,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned END_BIT      = 31
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               microcode_sequencer_load_n,
  input  logic                               microcode_sequencer_enable,
  input  logic                               microcode_rom_read_enable,
  input  logic [OPCODE_WIDTH-1:0]            opcode,
  output logic [OPCODE_WIDTH+STEP_WIDTH-1:0] rom_address,
  input  logic [WORD_WIDTH-1:0]              rom_data,
  output logic [WORD_WIDTH-1:0]              control_word,
  output logic                               instruction_finish_control_line,
  output logic [STEP_WIDTH-1:0]              step,
  output logic                               overrun
);

  typedef enum logic [1:0] {StIdle, StActive, StDone, StFault} state_e;

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic                    overrun_q, overrun_d;
  logic                    word_valid;
  logic                    end_seen;

  // The ROM word only belongs to the running instruction while ACTIVE or DONE.
  assign word_valid = microcode_rom_read_enable && (state_q == StActive || state_q == StDone);
  assign end_seen   = rom_data[END_BIT];

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    step_d    = step_q;
    overrun_d = overrun_q;
    if (!microcode_sequencer_load_n) begin
      state_d   = StActive;
      opcode_d  = opcode;
      step_d    = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        StActive: begin
          if (microcode_sequencer_enable && microcode_rom_read_enable) begin
            if (end_seen) begin
              state_d = StDone;
            end else if (step_q == '1) begin
              // Saturate instead of wrapping back into the start of the routine.
              state_d   = StFault;
              overrun_d = 1'b1;
            end else begin
              step_d = step_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      step_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      step_q    <= step_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    rom_address                     = {opcode_q, step_q};
    control_word                    = word_valid ? rom_data : '0;
    instruction_finish_control_line = (state_q == StFault) || (word_valid && end_seen);
    step                            = step_q;
    overrun                         = overrun_q;
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Microcode address generator sitting directly downstream of the execution driver.
- Captures the current opcode when the driver pulses microcode_sequencer_load_n, then steps a micro-op counter while the driver holds microcode_sequencer_enable.
- Addresses the asynchronous microcode ROM and gates its output onto the control bus.
- Generates instruction_finish_control_line back to the driver from the END bit of the current microword.

Parameters:
OPCODE_WIDTH, 8, width of the opcode field captured from the instruction
STEP_WIDTH, 4, micro-step counter width; max 2^STEP_WIDTH micro-ops per opcode
WORD_WIDTH, 32, microword width
END_BIT, 31, bit index of the end-of-instruction flag inside the microword

Ports:
clock  input  1  system clock; all state updates on posedge
reset_n  input  1  synchronous active-low reset
microcode_sequencer_load_n  input  1  active-low load of opcode, step cleared
microcode_sequencer_enable  input  1  advance step each cycle while high
microcode_rom_read_enable  input  1  gates the ROM word onto control_word and finish
opcode  input  OPCODE_WIDTH  opcode field of the current instruction
rom_address  output  OPCODE_WIDTH+STEP_WIDTH  {opcode_reg, step} to the asynchronous ROM
rom_data  input  WORD_WIDTH  ROM word at rom_address, same-cycle combinational
control_word  output  WORD_WIDTH  gated microword to the datapath
instruction_finish_control_line  output  1  current micro-op is last, or fault
step  output  STEP_WIDTH  current micro-step, for debug
overrun  output  1  sticky: counter ran past last step without END

Behaviour:
- Interface timing: one clock (clock); reset is synchronous, active-low (reset_n), sampled on posedge clock.
- Reset (reset_n=0 at posedge) values:
  - state IDLE, opcode_reg 0, step 0, overrun 0.
  - Outputs: rom_address 0, control_word 0, instruction_finish_control_line 0.
  - Reset mid-instruction aborts it immediately and takes priority over everything.
- State machine, evaluated at posedge in priority order: reset_n, then load, then state logic.
  - Load: load_n=0 from any state -> opcode_reg<=opcode, step<=0, overrun<=0, state ACTIVE. Load wins over a simultaneous enable; step is 0, not 1.
  - IDLE: holds until load.
  - ACTIVE, advance: enable=1, rom_read_enable=1, rom_data[END_BIT]=0.
    - step<=step+1.
    - If step is all-ones: step holds, overrun<=1, state FAULT. No wrap to 0.
  - ACTIVE, END seen: enable=1, rom_read_enable=1, rom_data[END_BIT]=1 -> state DONE, step holds.
  - ACTIVE, no advance: enable=0 or rom_read_enable=0 -> step holds. Enable without rom_read_enable never advances.
  - DONE: step frozen regardless of enable; leaves only on load or reset.
  - FAULT: step frozen; leaves only on load (clears overrun) or reset.
- Combinational outputs:
  - rom_address = {opcode_reg, step}, valid from the cycle after load.
  - control_word = rom_data when rom_read_enable=1 and state is ACTIVE or DONE; otherwise 0.
  - instruction_finish_control_line = (state==FAULT) OR (rom_read_enable AND state in {ACTIVE, DONE} AND rom_data[END_BIT]).
  - In FAULT, control_word=0 and finish=1 so the driver always releases.
- Latency and driver timing:
  - The driver changes controls on negedge; this block samples on posedge.
  - Load at posedge N makes rom_address and finish valid before negedge N.
  - A 1-cycle opcode is therefore detected by the driver's next negedge check.
  - Each enabled posedge advances exactly one step.
- Width rule: step arithmetic is STEP_WIDTH bits, unsigned, saturating at FAULT as above.
- Jump/halt: the driver drops enable and rom_read_enable.
  - Sequencer holds step; control_word goes to 0 and finish deasserts unless in FAULT.
  - The next load restarts cleanly.

Test Plan:
- Reset: reset_n=0 for 2 cycles with random inputs -> rom_address=0, control_word=0, finish=0, overrun=0, step=0; no advance with enable=1 while in IDLE.
- Single-step opcode: opcode=0x12, load_n low 1 cycle, ROM word at 0x120 has END=1, rom_read_enable=1 -> rom_address=0x120, finish=1 before next negedge, state DONE, step stays 0 with enable=1.
- Multi-step opcode: opcode=0x05, END only at step 3, enable=1 -> rom_address 0x050,0x051,0x052,0x053 on consecutive cycles; finish=1 only at 0x053; step frozen at 3 thereafter.
- Overrun: opcode=0x07, no END in any word, enable=1 -> step reaches 15, next posedge overrun=1, finish=1, control_word=0, step=15; a subsequent load of 0x08 clears overrun, step=0.
- Load priority and hold: load_n=0 with enable=1 mid-instruction at step 2 -> step=0, new opcode captured. enable=1 with rom_read_enable=0 -> step unchanged and control_word=0.
- Reset mid-operation: reset_n=0 at step 5 of a running opcode -> all outputs return to reset values next posedge, state IDLE.
